// File: rtl/pb_irq_ctrl_if.sv
// pb_irq_ctrl_if: kcpsm6 port bus and interrupt handshake between the CPU and pb_irq_ctrl
//   port_id/write_strobe/out_port/read_strobe : CPU I/O port bus
//   rd_data/rd_hit                            : registered read data and in_port mux select
//   interrupt/interrupt_ack                   : interrupt request and CPU acknowledge
interface pb_irq_ctrl_if;
    logic [7:0] port_id;
    logic       write_strobe;
    logic [7:0] out_port;
    logic       read_strobe;
    logic [7:0] rd_data;
    logic       rd_hit;
    logic       interrupt;
    logic       interrupt_ack;
    modport master (
        output port_id, write_strobe, out_port, read_strobe, interrupt_ack,
        input  rd_data, rd_hit, interrupt
    );
    modport slave (
        input  port_id, write_strobe, out_port, read_strobe, interrupt_ack,
        output rd_data, rd_hit, interrupt
    );
endinterface

// File: rtl/pb_irq_ctrl.sv
// pb_irq_ctrl: 8-source edge-triggered interrupt controller for kcpsm6
//   clk, reset : system clock, synchronous active-high reset
//   irq_src    : interrupt sources, rising edge requests service
//   bus        : CPU port bus and interrupt handshake (slave side)
//   Registers at BASE_PORT+0 MASK, +1 PENDING (W1C), +2 VECTOR, +3 EOI
module pb_irq_ctrl #(
    parameter logic [7:0] BASE_PORT = 8'hF0
) (
    input logic         clk,
    input logic         reset,
    input logic [7:0]   irq_src,
    pb_irq_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, ASSERT = 2'd1, WAIT_EOI = 2'd2;
    logic [1:0] state;
    logic [7:0] prev, mask, pending, act, edge_v, w1c, take, rd_mux, rd_data_q;
    logic [2:0] vec_idx, idx;
    logic       hit, wr, eoi, start, rd_hit_q, unused;
    logic [1:0] off;
    assign edge_v = irq_src & ~prev;
    assign hit    = bus.port_id[7:2] == BASE_PORT[7:2];
    assign off    = bus.port_id[1:0];
    assign wr     = bus.write_strobe & hit;
    assign eoi    = wr && off == 2'd3;
    assign w1c    = (wr && off == 2'd1) ? bus.out_port : 8'h00;
    assign act    = pending & mask;
    assign start  = state == IDLE && |act;
    assign take   = start ? 8'h01 << idx : 8'h00;
    assign unused = bus.read_strobe;
    // lowest set index wins
    always_comb begin
        idx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (act[i]) idx = i[2:0];
    end
    always_comb begin
        rd_mux = off == 2'd0 ? mask :
                 off == 2'd1 ? pending :
                 off == 2'd2 ? {state == WAIT_EOI, 4'b0, vec_idx} : 8'h00;
        rd_mux = hit ? rd_mux : 8'h00;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            // sources already high at reset release must not look like edges
            prev      <= irq_src;
            mask      <= 8'h00;
            pending   <= 8'h00;
            vec_idx   <= 3'd0;
            state     <= IDLE;
            rd_data_q <= 8'h00;
            rd_hit_q  <= 1'b0;
        end else begin
            prev      <= irq_src;
            // new edges win over both W1C and the IDLE take
            pending   <= (pending & ~w1c & ~take) | edge_v;
            mask      <= (wr && off == 2'd0) ? bus.out_port : mask;
            vec_idx   <= start ? idx : vec_idx;
            rd_data_q <= rd_mux;
            rd_hit_q  <= hit;
            case (state)
                IDLE:     state <= start ? ASSERT : IDLE;
                ASSERT:   state <= bus.interrupt_ack ? WAIT_EOI : ASSERT;
                WAIT_EOI: state <= eoi ? IDLE : WAIT_EOI;
                default:  state <= IDLE;
            endcase
        end
    end
    assign bus.interrupt = state == ASSERT;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_hit    = rd_hit_q;
endmodule

// File: tb/tb_pb_irq_ctrl.sv
// tb_pb_irq_ctrl: scoreboard bench for pb_irq_ctrl with directed vectors
module tb_pb_irq_ctrl;
    localparam logic [7:0] B = 8'hF0;
    localparam int INT = 0, RD = 1, HIT = 2;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] irq_src = 8'hFF;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] val;
        string      name;
    } exp_t;
    exp_t sb[$];
    pb_irq_ctrl_if bus();
    pb_irq_ctrl #(.BASE_PORT(B)) dut (
        .clk(clk),
        .reset(reset),
        .irq_src(irq_src),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        logic [7:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                act = sb[i].sel == INT ? {7'b0, bus.interrupt} :
                      sb[i].sel == RD  ? bus.rd_data : {7'b0, bus.rd_hit};
                checks++;
                if (sb[i].cyc != cyc || act !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s cyc %0d got %h expected %h", sb[i].name, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic want(input int dc, input int sel, input logic [7:0] val, input string nm);
        sb.push_back('{cyc + dc, sel, val, nm});
    endtask
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.port_id = a;
        bus.out_port = d;
        bus.write_strobe = 1'b1;
        step();
        bus.write_strobe = 1'b0;
        bus.port_id = 8'h00;
    endtask
    task automatic rd(input logic [7:0] a, input logic [7:0] v, input logic h, input string nm);
        bus.port_id = a;
        bus.read_strobe = 1'b1;
        want(1, RD, v, nm);
        want(1, HIT, {7'b0, h}, {nm, "_hit"});
        step();
        bus.read_strobe = 1'b0;
        bus.port_id = 8'h00;
    endtask
    task automatic ack();
        bus.interrupt_ack = 1'b1;
        want(0, INT, 8'h01, "int_before_ack");
        want(1, INT, 8'h00, "int_after_ack");
        step();
        bus.interrupt_ack = 1'b0;
    endtask
    initial begin
        bus.port_id = 8'h00;
        bus.out_port = 8'h00;
        bus.write_strobe = 1'b0;
        bus.read_strobe = 1'b0;
        bus.interrupt_ack = 1'b0;
        step();
        step();
        want(0, INT, 8'h00, "rst_int");
        want(0, RD, 8'h00, "rst_rd_data");
        want(0, HIT, 8'h00, "rst_rd_hit");
        step();
        // release reset with all sources high; enable all so a false edge would interrupt
        reset = 1'b0;
        step();
        wr(B, 8'hFF);
        for (int i = 0; i < 20; i++) begin
            want(0, INT, 8'h00, "hi_at_reset_no_int");
            step();
        end
        rd(B + 8'd1, 8'h00, 1'b1, "hi_at_reset_pending");
        irq_src = 8'h00;
        wr(B, 8'h04);
        step();
        // single source 2
        irq_src = 8'h04;
        want(1, INT, 8'h00, "src2_n1");
        want(2, INT, 8'h01, "src2_n2");
        step();
        irq_src = 8'h00;
        step();
        rd(B + 8'd2, 8'h02, 1'b1, "src2_vec");
        ack();
        rd(B + 8'd2, 8'h82, 1'b1, "src2_vec_svc");
        wr(B + 8'd3, 8'h00);
        rd(B + 8'd2, 8'h02, 1'b1, "src2_vec_eoi");
        want(0, INT, 8'h00, "src2_idle");
        step();
        // simultaneous sources 5 and 1
        wr(B, 8'hFF);
        irq_src = 8'h22;
        want(2, INT, 8'h01, "pri_int");
        step();
        irq_src = 8'h00;
        step();
        rd(B + 8'd2, 8'h01, 1'b1, "pri_vec1");
        rd(B + 8'd1, 8'h20, 1'b1, "pri_pend");
        ack();
        want(1, INT, 8'h00, "pri_eoi_k1");
        want(2, INT, 8'h01, "pri_eoi_k2");
        wr(B + 8'd3, 8'h00);
        step();
        rd(B + 8'd2, 8'h05, 1'b1, "pri_vec5");
        rd(B + 8'd1, 8'h00, 1'b1, "pri_pend_taken");
        ack();
        wr(B + 8'd3, 8'h00);
        step();
        // masked source 3, then enable
        wr(B, 8'h00);
        irq_src = 8'h08;
        step();
        irq_src = 8'h00;
        want(0, INT, 8'h00, "masked_no_int");
        step();
        rd(B + 8'd1, 8'h08, 1'b1, "masked_pend");
        want(1, INT, 8'h00, "unmask_w1");
        want(2, INT, 8'h01, "unmask_w2");
        wr(B, 8'h08);
        step();
        ack();
        wr(B + 8'd3, 8'h00);
        step();
        // W1C colliding with a new edge, then plain W1C
        wr(B, 8'h00);
        irq_src = 8'h08;
        wr(B + 8'd1, 8'h08);
        irq_src = 8'h00;
        rd(B + 8'd1, 8'h08, 1'b1, "w1c_set_wins");
        wr(B + 8'd1, 8'h08);
        rd(B + 8'd1, 8'h00, 1'b1, "w1c_clear");
        // mask cleared during ASSERT, then reset in WAIT_EOI
        wr(B, 8'hFF);
        irq_src = 8'h01;
        step();
        irq_src = 8'h00;
        step();
        want(0, INT, 8'h01, "hold_mask0");
        wr(B, 8'h00);
        for (int i = 0; i < 3; i++) begin
            want(0, INT, 8'h01, "hold_mask0");
            step();
        end
        ack();
        irq_src = 8'h10;
        step();
        irq_src = 8'h00;
        rd(B + 8'd1, 8'h10, 1'b1, "svc_pend");
        rd(B + 8'd2, 8'h80, 1'b1, "svc_vec");
        rd(B + 8'd5, 8'h00, 1'b0, "unmapped");
        wr(B, 8'hAA);
        reset = 1'b1;
        bus.port_id = B + 8'd1;
        want(1, INT, 8'h00, "midrst_int");
        want(1, RD, 8'h00, "midrst_rd");
        want(1, HIT, 8'h00, "midrst_hit");
        step();
        reset = 1'b0;
        bus.port_id = 8'h00;
        rd(B, 8'h00, 1'b1, "midrst_mask");
        rd(B + 8'd1, 8'h00, 1'b1, "midrst_pend");
        rd(B + 8'd2, 8'h00, 1'b1, "midrst_vec");
        want(0, INT, 8'h00, "midrst_idle");
        step();
        step();
        step();
        if (sb.size() != 0) begin
            errors += sb.size();
            $display("FAIL scoreboard_leftover count %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
